// File: rtl/mips_pkg.sv
// Shared encodings and the decode-to-execute control word for the MIPS pipeline control path.
package mips_pkg;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC8 = 2'b10;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       mem_write;
        logic [2:0] alu_control;
        logic       alu_src;
        logic [1:0] reg_dst;
        logic       load;
    } ctrl_e_t;

    localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// Control-word pipeline register; reset or flush loads BUBBLE, otherwise loads the input each cycle.
module ctrl_stage_reg #(
    parameter int           W      = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            o_q <= BUBBLE;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Carries decode control through E/M/W and derives stall, flush and forward selects from in-flight state.
module hazard_ctrl_pipe
    import mips_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int RA_REG = 31
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_RegWriteD,
    input  logic              i_MemWriteD,
    input  logic              i_ALUSrcD,
    input  logic              i_LoadD,
    input  logic              i_BranchD,
    input  logic              i_JumpRD,
    input  logic [1:0]        i_MemtoRegD,
    input  logic [1:0]        i_RegDstD,
    input  logic [2:0]        i_ALUControlD,
    input  logic              i_PCSrcD,
    input  logic [REG_AW-1:0] i_RsD,
    input  logic [REG_AW-1:0] i_RtD,
    input  logic [REG_AW-1:0] i_RdD,
    output logic              o_StallF,
    output logic              o_StallD,
    output logic              o_FlushD,
    output logic              o_FlushE,
    output logic              o_ForwardAD,
    output logic              o_ForwardBD,
    output logic [1:0]        o_ForwardAE,
    output logic [1:0]        o_ForwardBE,
    output logic              o_RegWriteE,
    output logic              o_RegWriteM,
    output logic              o_RegWriteW,
    output logic [1:0]        o_MemtoRegE,
    output logic [1:0]        o_MemtoRegM,
    output logic [1:0]        o_MemtoRegW,
    output logic              o_MemWriteE,
    output logic              o_MemWriteM,
    output logic [2:0]        o_ALUControlE,
    output logic              o_ALUSrcE,
    output logic [1:0]        o_RegDstE,
    output logic              o_LoadE,
    output logic              o_LoadM,
    output logic [REG_AW-1:0] o_RsE,
    output logic [REG_AW-1:0] o_RtE,
    output logic [REG_AW-1:0] o_RdE,
    output logic [REG_AW-1:0] o_WriteRegE,
    output logic [REG_AW-1:0] o_WriteRegM,
    output logic [REG_AW-1:0] o_WriteRegW
);

    localparam int CW = $bits(ctrl_e_t);
    localparam int EW = CW + 3 * REG_AW;
    localparam int MW = 5 + REG_AW;
    localparam int WW = 3 + REG_AW;
    localparam logic [REG_AW-1:0] RA = REG_AW'(RA_REG);

    ctrl_e_t           ctrl_d;
    ctrl_e_t           ctrl_e;
    logic [EW-1:0]     de_q;
    logic [MW-1:0]     em_q;
    logic [WW-1:0]     mw_q;
    logic [REG_AW-1:0] rs_e, rt_e, rd_e;
    logic [REG_AW-1:0] write_reg_e, write_reg_m, write_reg_w;
    logic              reg_write_m, mem_write_m, load_m, reg_write_w;
    logic [1:0]        mem_to_reg_m, mem_to_reg_w;
    logic              lwstall, brstall, stall;
    logic              rs_hit, rt_hit;

    assign ctrl_d = '{
        reg_write:   i_RegWriteD,
        mem_to_reg:  i_MemtoRegD,
        mem_write:   i_MemWriteD,
        alu_control: i_ALUControlD,
        alu_src:     i_ALUSrcD,
        reg_dst:     i_RegDstD,
        load:        i_LoadD
    };

    ctrl_stage_reg #(.W(EW), .BUBBLE({CTRL_BUBBLE, {(3*REG_AW){1'b0}}})) u_de (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (stall),
        .i_d     ({ctrl_d, i_RsD, i_RtD, i_RdD}),
        .o_q     (de_q)
    );
    assign {ctrl_e, rs_e, rt_e, rd_e} = de_q;

    always_comb begin
        write_reg_e = rt_e;
        case (ctrl_e.reg_dst)
            RDST_RD: write_reg_e = rd_e;
            RDST_RA: write_reg_e = RA;
            default: write_reg_e = rt_e;
        endcase
    end

    ctrl_stage_reg #(.W(MW)) u_em (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (1'b0),
        .i_d     ({ctrl_e.reg_write, ctrl_e.mem_to_reg, ctrl_e.mem_write, ctrl_e.load, write_reg_e}),
        .o_q     (em_q)
    );
    assign {reg_write_m, mem_to_reg_m, mem_write_m, load_m, write_reg_m} = em_q;

    ctrl_stage_reg #(.W(WW)) u_mw (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (1'b0),
        .i_d     ({reg_write_m, mem_to_reg_m, write_reg_m}),
        .o_q     (mw_q)
    );
    assign {reg_write_w, mem_to_reg_w, write_reg_w} = mw_q;

    // A decode operand still being produced by an ALU op in E or a load in M cannot be compared yet.
    assign rs_hit = (i_RsD != '0) &&
                    ((ctrl_e.reg_write && (write_reg_e == i_RsD)) || (load_m && (write_reg_m == i_RsD)));
    assign rt_hit = (i_RtD != '0) &&
                    ((ctrl_e.reg_write && (write_reg_e == i_RtD)) || (load_m && (write_reg_m == i_RtD)));

    assign lwstall = ctrl_e.load && (rt_e != '0) && ((rt_e == i_RsD) || (rt_e == i_RtD));
    assign brstall = (i_BranchD && (rs_hit || rt_hit)) || (i_JumpRD && rs_hit);
    assign stall   = lwstall || brstall;

    assign o_StallF = stall;
    assign o_StallD = stall;
    assign o_FlushE = stall;
    assign o_FlushD = i_PCSrcD && !stall;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (reg_write_m && (src == write_reg_m)) begin
                sel = FWD_M;
            end else if (reg_write_w && (src == write_reg_w)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    assign o_ForwardAE = fwd_sel(rs_e);
    assign o_ForwardBE = fwd_sel(rt_e);
    assign o_ForwardAD = (i_RsD != '0) && reg_write_m && (i_RsD == write_reg_m);
    assign o_ForwardBD = (i_RtD != '0) && reg_write_m && (i_RtD == write_reg_m);

    assign o_RegWriteE   = ctrl_e.reg_write;
    assign o_MemtoRegE   = ctrl_e.mem_to_reg;
    assign o_MemWriteE   = ctrl_e.mem_write;
    assign o_ALUControlE = ctrl_e.alu_control;
    assign o_ALUSrcE     = ctrl_e.alu_src;
    assign o_RegDstE     = ctrl_e.reg_dst;
    assign o_LoadE       = ctrl_e.load;
    assign o_RsE         = rs_e;
    assign o_RtE         = rt_e;
    assign o_RdE         = rd_e;
    assign o_WriteRegE   = write_reg_e;

    assign o_RegWriteM = reg_write_m;
    assign o_MemtoRegM = mem_to_reg_m;
    assign o_MemWriteM = mem_write_m;
    assign o_LoadM     = load_m;
    assign o_WriteRegM = write_reg_m;

    assign o_RegWriteW = reg_write_w;
    assign o_MemtoRegW = mem_to_reg_w;
    assign o_WriteRegW = write_reg_w;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Randomized and directed bench for hazard_ctrl_pipe against an instruction-level pipeline model.
module tb_hazard_ctrl_pipe;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic       asrc;
        logic       ld;
        logic [1:0] mtr;
        logic [1:0] rdst;
        logic [2:0] aluc;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    instr_t d = '0;
    logic br = 1'b0, jr = 1'b0, pcs = 1'b0;

    logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic       RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM, ALUSrcE, LoadE, LoadM;
    logic [1:0] MemtoRegE, MemtoRegM, MemtoRegW, RegDstE;
    logic [2:0] ALUControlE;
    logic [4:0] RsE, RtE, RdE, WriteRegE, WriteRegM, WriteRegW;

    int checks = 0;
    int errors = 0;

    // In-flight instructions as the model sees them; a bubble is an all-zero instruction.
    instr_t me, mm, mwb;
    logic   exp_stall;

    always #5 clk = ~clk;

    hazard_ctrl_pipe #(.REG_AW(5), .RA_REG(31)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_RegWriteD(d.rw), .i_MemWriteD(d.mw), .i_ALUSrcD(d.asrc), .i_LoadD(d.ld),
        .i_BranchD(br), .i_JumpRD(jr), .i_MemtoRegD(d.mtr), .i_RegDstD(d.rdst),
        .i_ALUControlD(d.aluc), .i_PCSrcD(pcs), .i_RsD(d.rs), .i_RtD(d.rt), .i_RdD(d.rd),
        .o_StallF(StallF), .o_StallD(StallD), .o_FlushD(FlushD), .o_FlushE(FlushE),
        .o_ForwardAD(ForwardAD), .o_ForwardBD(ForwardBD), .o_ForwardAE(ForwardAE), .o_ForwardBE(ForwardBE),
        .o_RegWriteE(RegWriteE), .o_RegWriteM(RegWriteM), .o_RegWriteW(RegWriteW),
        .o_MemtoRegE(MemtoRegE), .o_MemtoRegM(MemtoRegM), .o_MemtoRegW(MemtoRegW),
        .o_MemWriteE(MemWriteE), .o_MemWriteM(MemWriteM), .o_ALUControlE(ALUControlE),
        .o_ALUSrcE(ALUSrcE), .o_RegDstE(RegDstE), .o_LoadE(LoadE), .o_LoadM(LoadM),
        .o_RsE(RsE), .o_RtE(RtE), .o_RdE(RdE),
        .o_WriteRegE(WriteRegE), .o_WriteRegM(WriteRegM), .o_WriteRegW(WriteRegW)
    );

    function automatic logic [4:0] dest(input instr_t i);
        if (i.rdst == 2'b01) return i.rd;
        if (i.rdst == 2'b10) return 5'd31;
        return i.rt;
    endfunction

    // Is register r still being produced where decode cannot see it (ALU op in E, load in M)?
    function automatic logic pending(input logic [4:0] r);
        if (r == 0) return 1'b0;
        return (me.rw && dest(me) == r) || (mm.ld && dest(mm) == r);
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] r);
        if (r == 0) return 2'd0;
        if (mm.rw && dest(mm) == r) return 2'd2;
        if (mwb.rw && dest(mwb) == r) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        logic lw, bs;
        lw = me.ld && me.rt != 0 && (me.rt == d.rs || me.rt == d.rt);
        bs = (br && (pending(d.rs) || pending(d.rt))) || (jr && pending(d.rs));
        exp_stall = lw || bs;
        chk("StallF", 8'(StallF), 8'(exp_stall));
        chk("StallD", 8'(StallD), 8'(exp_stall));
        chk("FlushE", 8'(FlushE), 8'(exp_stall));
        chk("FlushD", 8'(FlushD), 8'(pcs && !exp_stall));
        chk("ForwardAD", 8'(ForwardAD), 8'(d.rs != 0 && mm.rw && dest(mm) == d.rs));
        chk("ForwardBD", 8'(ForwardBD), 8'(d.rt != 0 && mm.rw && dest(mm) == d.rt));
        chk("ForwardAE", 8'(ForwardAE), 8'(fwd(me.rs)));
        chk("ForwardBE", 8'(ForwardBE), 8'(fwd(me.rt)));
        chk("RegWriteE", 8'(RegWriteE), 8'(me.rw));
        chk("MemtoRegE", 8'(MemtoRegE), 8'(me.mtr));
        chk("MemWriteE", 8'(MemWriteE), 8'(me.mw));
        chk("ALUControlE", 8'(ALUControlE), 8'(me.aluc));
        chk("ALUSrcE", 8'(ALUSrcE), 8'(me.asrc));
        chk("RegDstE", 8'(RegDstE), 8'(me.rdst));
        chk("LoadE", 8'(LoadE), 8'(me.ld));
        chk("RsE", 8'(RsE), 8'(me.rs));
        chk("RtE", 8'(RtE), 8'(me.rt));
        chk("RdE", 8'(RdE), 8'(me.rd));
        chk("WriteRegE", 8'(WriteRegE), 8'(dest(me)));
        chk("RegWriteM", 8'(RegWriteM), 8'(mm.rw));
        chk("MemtoRegM", 8'(MemtoRegM), 8'(mm.mtr));
        chk("MemWriteM", 8'(MemWriteM), 8'(mm.mw));
        chk("LoadM", 8'(LoadM), 8'(mm.ld));
        chk("WriteRegM", 8'(WriteRegM), 8'(dest(mm)));
        chk("RegWriteW", 8'(RegWriteW), 8'(mwb.rw));
        chk("MemtoRegW", 8'(MemtoRegW), 8'(mwb.mtr));
        chk("WriteRegW", 8'(WriteRegW), 8'(dest(mwb)));
    endtask

    task automatic drive(input instr_t di, input logic b, input logic j, input logic p, input logic r);
        @(negedge clk);
        d = di; br = b; jr = j; pcs = p; rst = r;
        #1;
        cmp_all();
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            me = '0; mm = '0; mwb = '0;
        end else begin
            mwb = mm;
            mm  = me;
            me  = exp_stall ? instr_t'('0) : d;
        end
    endtask

    function automatic instr_t mk(input logic rw, input logic ld, input logic [1:0] mtr,
                                  input logic [1:0] rdst, input int rs, input int rt, input int rd);
        instr_t i;
        i = '0;
        i.rw = rw; i.ld = ld; i.mtr = mtr; i.rdst = rdst;
        i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
        return i;
    endfunction

    initial begin
        instr_t nop, lw8, add98, lw3, beq34, jal, wr5a, wr5b, use5, wr0, use0, ri;
        nop   = '0;
        lw8   = mk(1, 1, 2'b01, 2'b00, 0, 8, 0);
        add98 = mk(1, 0, 2'b00, 2'b01, 8, 10, 9);
        lw3   = mk(1, 1, 2'b01, 2'b00, 0, 3, 0);
        beq34 = mk(0, 0, 2'b00, 2'b00, 3, 4, 0);
        jal   = mk(1, 0, 2'b10, 2'b10, 0, 0, 0);
        wr5a  = mk(1, 0, 2'b00, 2'b01, 1, 2, 5);
        wr5b  = mk(1, 0, 2'b00, 2'b01, 6, 7, 5);
        use5  = mk(1, 0, 2'b00, 2'b01, 5, 6, 12);
        wr0   = mk(1, 0, 2'b00, 2'b01, 1, 2, 0);
        use0  = mk(1, 0, 2'b00, 2'b01, 0, 0, 13);
        me = '0; mm = '0; mwb = '0; exp_stall = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state
        drive(nop, 0, 0, 0, 0);
        chk("rst_RegWriteW", 8'(RegWriteW), 8'd0);
        chk("rst_StallF", 8'(StallF), 8'd0);
        adv();

        // Load-use: one stall, bubble in E, then W forward
        drive(lw8, 0, 0, 0, 0); adv();
        drive(add98, 0, 0, 0, 0);
        chk("lu_stall", 8'(StallF), 8'd1);
        adv();
        drive(add98, 0, 0, 0, 0);
        chk("lu_nostall", 8'(StallD), 8'd0);
        chk("lu_bubble_rwE", 8'(RegWriteE), 8'd0);
        adv();
        drive(nop, 0, 0, 0, 0);
        chk("lu_fwdAE", 8'(ForwardAE), 8'd1);
        adv();

        // Double forward: M wins over W
        drive(wr5a, 0, 0, 0, 0); adv();
        drive(wr5b, 0, 0, 0, 0); adv();
        drive(use5, 0, 0, 0, 0); adv();
        drive(nop, 0, 0, 0, 0);
        chk("dbl_fwdAE", 8'(ForwardAE), 8'd2);
        adv();

        // Zero register never forwards
        drive(wr0, 0, 0, 0, 0); adv();
        drive(use0, 0, 0, 0, 0); adv();
        drive(nop, 0, 0, 0, 0);
        chk("zero_fwdAE", 8'(ForwardAE), 8'd0);
        chk("zero_stall", 8'(StallF), 8'd0);
        adv();

        // Branch after load: two stalls, redirect only afterwards
        drive(lw3, 0, 0, 0, 0); adv();
        drive(beq34, 1, 0, 1, 0);
        chk("bl_stall1", 8'(StallF), 8'd1);
        chk("bl_flushD1", 8'(FlushD), 8'd0);
        adv();
        drive(beq34, 1, 0, 1, 0);
        chk("bl_stall2", 8'(StallF), 8'd1);
        adv();
        drive(beq34, 1, 0, 1, 0);
        chk("bl_stall3", 8'(StallF), 8'd0);
        chk("bl_fwdAD", 8'(ForwardAD), 8'd0);
        chk("bl_flushD3", 8'(FlushD), 8'd1);
        adv();

        // JAL staging
        drive(jal, 0, 0, 0, 0); adv();
        drive(nop, 0, 0, 0, 0);
        chk("jal_wrE", 8'(WriteRegE), 8'd31);
        adv();
        drive(nop, 0, 0, 0, 0); adv();
        drive(nop, 0, 0, 0, 0);
        chk("jal_wrW", 8'(WriteRegW), 8'd31);
        chk("jal_mtrW", 8'(MemtoRegW), 8'd2);
        adv();

        // Reset mid-stall
        drive(lw8, 0, 0, 0, 0); adv();
        drive(add98, 0, 0, 0, 0);
        chk("rs_stall", 8'(StallF), 8'd1);
        adv();
        drive(add98, 0, 0, 0, 1); adv();
        drive(add98, 0, 0, 0, 0);
        chk("rs_stallF", 8'(StallF), 8'd0);
        chk("rs_rwE", 8'(RegWriteE), 8'd0);
        chk("rs_rwM", 8'(RegWriteM), 8'd0);
        chk("rs_rwW", 8'(RegWriteW), 8'd0);
        chk("rs_ldM", 8'(LoadM), 8'd0);
        adv();

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            ri = instr_t'({$urandom, $urandom});
            ri.rs = 5'($urandom_range(0, 7));
            ri.rt = 5'($urandom_range(0, 7));
            ri.rd = 5'($urandom_range(0, 7));
            drive(ri, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_pipe.md
# hazard_ctrl_pipe

Pipeline control carrier and hazard unit for the 5-stage MIPS core. It accepts the decode-stage control word and register specifiers produced by the control unit, then carries them through the ID/EX, EX/MEM and MEM/WB registers. Each cycle it derives stall, flush and forwarding selects from the in-flight copies. It sits beside the datapath pipeline registers as the single owner of all control-side state after decode.

## Interface
Parameters:
- `REG_AW`, 5: register specifier width
- `RA_REG`, 31: link register written when `RegDst` is 2'b10

Ports:
- `i_clk`  in  1: core clock; every register updates on the rising edge
- `i_rst`  in  1: reset, synchronous and active-high
- `i_RegWriteD`, `i_MemWriteD`, `i_ALUSrcD`, `i_LoadD`, `i_BranchD`, `i_JumpRD`  in  1 each: decode control bits
- `i_MemtoRegD`  in  2: 00 ALU, 01 memory, 10 PC+8
- `i_RegDstD`  in  2: 00 rt, 01 rd, 10 `RA_REG`
- `i_ALUControlD`  in  3: ALU operation code
- `i_PCSrcD`  in  1: redirect taken in decode
- `i_RsD`, `i_RtD`, `i_RdD`  in  `REG_AW` each: decode register specifiers
- `o_StallF`, `o_StallD`, `o_FlushD`, `o_FlushE`  out  1 each: hazard controls
- `o_ForwardAD`, `o_ForwardBD`  out  1 each: decode-stage comparator forward from M
- `o_ForwardAE`, `o_ForwardBE`  out  2 each: 00 register file, 01 from W, 10 from M
- `o_RegWriteE/M/W`, `o_MemtoRegE/M/W`, `o_MemWriteE/M`, `o_ALUControlE`, `o_ALUSrcE`, `o_RegDstE`, `o_LoadE/M`  out: staged control bits, same widths as the D inputs
- `o_RsE`, `o_RtE`, `o_RdE`  out  `REG_AW` each: staged specifiers
- `o_WriteRegE/M/W`  out  `REG_AW` each: resolved destination register

## Operation
- `WriteRegE` is a combinational function of `RegDstE`: rt, rd or `RA_REG`. Encoding 2'b11 resolves to rt.
- `WriteRegM` and `WriteRegW` are registered copies of `WriteRegE` and `WriteRegM`.
- Load-use stall, `lwstall` = `LoadE` & (`RtE`==`RsD` | `RtE`==`RtD`) & `RtE`!=0.
- Branch stall, `brstall`:
  - Applies when `BranchD` is set and `RsD` or `RtD` matches, or when `JumpRD` is set and `RsD` alone matches.
  - A match is either `RegWriteE` & `WriteRegE` = specifier, or `LoadM` & `WriteRegM` = specifier.
  - A specifier equal to 0 never matches.
- `StallF` = `StallD` = `FlushE` = `lwstall` | `brstall`.
- `FlushD` = `i_PCSrcD` & ~`StallD`.
- `ForwardAE`:
  - 10 when `RsE`!=0, `RegWriteM` is set and `RsE`==`WriteRegM`.
  - Otherwise 01 when `RsE`!=0, `RegWriteW` is set and `RsE`==`WriteRegW`.
  - Otherwise 00.
- `ForwardBE` uses the same rules with `RtE`. M has priority over W.
- `ForwardAD` = `RsD`!=0 & `RegWriteM` & `RsD`==`WriteRegM`. `ForwardBD` is the same with `RtD`.
- D→E register: loads the D inputs every cycle. When `FlushE` is set, it loads the bubble instead.
- Bubble: all control bits, `MemtoReg`, `RegDst`, `ALUControl` and specifiers are 0.
- E→M and M→W registers: always advance; they have no enable.
- `i_PCSrcD` only drives `FlushD`. It is not staged, and the IF/ID register itself is external.

## Timing
- Hazard and forward outputs are combinational from current pipeline state plus the D inputs, with zero-cycle latency.
- A load in E followed by a dependent instruction in D gives exactly 1 stall cycle: bubble in E, then the consumer sees `ForwardAE`/`ForwardBE`=01.
- A branch dependent on an ALU result in E stalls 1 cycle. A branch dependent on a load in E stalls 2 cycles: `lwstall`, then `brstall` from `LoadM`.
- `lwstall` and `brstall` at the same time: one combined stall with a single bubble.
- `i_PCSrcD` together with a stall: `FlushD`=0, so the redirect is re-evaluated after the stall clears.
- Reset: every staged output is 0 on the edge where `i_rst` is sampled high, and all stage registers hold the bubble.
  - Hazard outputs are then driven only by the D inputs and the zeroed state.
  - A reset asserted mid-stall clears everything; no stall persists after release unless it is recomputed.
- A write to `$0` never forwards and never stalls.

## Structure
- Shared package `mips_pkg`: localparams for the `MemtoReg` encodings (`MTR_ALU`, `MTR_MEM`, `MTR_PC8`), `RegDst` encodings, forward-select encodings (`FWD_RF`, `FWD_W`, `FWD_M`) and the bubble control-word constant.
- One sub-module, `ctrl_stage_reg`: a parameter-width control-word register with synchronous clear and flush. It is instantiated three times: D→E with flush, E→M and M→W without.
- Hazard and forward logic lives in the top level.

## Test plan
- Load-use: `lw $8` in E (`LoadE`=1, `RtE`=8) with `add $9,$8,$10` in D → `StallF`/`StallD`/`FlushE`=1 for one cycle; the next cycle has `ForwardAE`=01 and `o_RegWriteE`=0 in the bubble.
- Double forward: `RegWriteM`=1 with `WriteRegM`=5, and `RegWriteW`=1 with `WriteRegW`=5, and `RsE`=5 → `ForwardAE`=10.
- Zero register: `RegWriteM`=1 with `WriteRegM`=0 and `RsE`=0 → `ForwardAE`=00 and no stall.
- Branch after load: `lw $3` then `beq $3,$4` → 2 stall cycles, then `ForwardAD`=0 with data from the register file via W; `FlushD`=1 only after the stalls if `i_PCSrcD`=1.
- JAL staging: `RegDstD`=10 and `MemtoRegD`=10 → `o_WriteRegE`=31, then `o_WriteRegW`=31 with `o_MemtoRegW`=10 two cycles later.
- Reset mid-stall: assert `i_rst` during `lwstall` → next cycle all E/M/W outputs are 0 and `StallF`=0.
